hazard_tag_pipe: RTL and testbench
==================================

Name: hazard_tag_pipe

Overview:
- Producer side of the pipeline hazard interface: carries each instruction's destination register, write-enable, store flag and remaining-latency tag (Tnew) from D through the E, M and W stages.
- Presents per-stage tags (Dst/RFWr/T for E, M and W; Rs/Rt in E; DMWr in M) to the stall/forward controller.
- Consumes that controller's E-stage flush, which inserts bubbles.
- Also keeps a saturating bubble counter for performance monitoring.

Parameters:
- TW, 3, width of the Tnew/T tag fields.
- CNTW, 32, width of the bubble counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RsD  in  5  rs field of the instruction in D.
- RtD  in  5  rt field of the instruction in D.
- DstD  in  5  destination register decoded in D.
- RFWrD  in  1  D instruction writes the register file.
- DMWrD  in  1  D instruction writes data memory.
- TnewD  in  TW  cycles, counted from E entry, until the D result is forwardable.
- FlushE  in  1  stall from the hazard controller; the next E contents become a bubble.
- FlushAll  in  1  squash E and M together (exception/return redirect).
- RsE, RtE  out  5  rs/rt of the instruction in E.
- DstE, DstM, DstW  out  5  destination register per stage.
- RFWrE, RFWrM, RFWrW  out  1  register write-enable per stage.
- TE, TM, TW_O  out  TW  remaining latency per stage.
- DMWrM  out  1  instruction in M is a store.
- BubbleCnt  out  CNTW  count of inserted bubbles.

Behaviour:
- Reset, synchronous on the clk edge while reset=1: every output register clears to 0, all stages hold bubbles, BubbleCnt=0. Reset wins over every other input.
- Bubble definition: Rs=Rt=Dst=0, RFWr=0, DMWr=0, T=0.
- Canonicalisation at D->E capture: if DstD==0, RFWr stored as 0. Dst and T are stored as given.
- Saturating decrement, dec(x) = (x==0) ? 0 : x-1.
- E register, each cycle:
  - FlushE or FlushAll → load a bubble.
  - Otherwise capture {RsD, RtD, DstD, RFWrD', DMWrD, TnewD}, where RFWrD' is the canonicalised write-enable.
- M register, each cycle:
  - FlushAll → load a bubble.
  - Otherwise capture E contents with T := dec(TE).
  - DMWrM = DMWr of E.
- W register, each cycle: capture M contents with T := dec(TM). DMWr is not carried into W. FlushAll never touches W, because the W instruction has committed.
- Latency: an instruction accepted in D at cycle n shows in E at n+1 with TE=TnewD, in M at n+2 with TM=dec(TnewD), and in W at n+3 with TW_O=dec(dec(TnewD)).
- The E register has no enable. A D-stage hold is always paired with FlushE by the controller, so the held D instruction is re-presented and re-captured the cycle after the stall clears. No double issue results, because E was a bubble during the stall.
- Simultaneous FlushE and FlushAll: equivalent to FlushAll alone.
- BubbleCnt:
  - Increments by 1 on every cycle where FlushE=1 and reset=0.
  - FlushAll alone does not count.
  - Saturates at all-ones; it does not wrap.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared header (head.v): TW default, the bubble field values, and the dec() function.
- One natural sub-module: hazard_tag_stage, a single stage register with bubble load and saturating T decrement.
  - Instantiated for E (decrement bypassed, Rs/Rt/DMWr fields used).
  - Instantiated for M and W (decrement enabled).
- The counter lives at top level.

Test Plan:
- Reset mid-stream: load 3 instructions, then assert reset one cycle → next cycle all Dst/RFWr/T outputs are 0 and BubbleCnt=0.
- Latency decay: DstD=8, RFWrD=1, TnewD=2 at cycle 0 → cycle1 DstE=8, TE=2; cycle2 DstM=8, TM=1; cycle3 DstW=8, TW_O=0.
- Saturation: TnewD=0, DstD=5 → TE=0, TM=0, TW_O=0 with RFWr=1 in every stage (no underflow to 7).
- Zero register: DstD=0, RFWrD=1 → RFWrE=0, and RFWrM=0, RFWrW=0 in later cycles.
- Stall: FlushE=1 for 2 cycles with the same D instruction (Dst=3) held → E is a bubble for 2 cycles, then DstE=3 exactly once; BubbleCnt=2.
- FlushAll with E holding Dst=4 and M holding Dst=6 → next cycle E and M are bubbles, W shows Dst=6, BubbleCnt unchanged; with the counter preloaded near all-ones, FlushE pulses leave BubbleCnt at all-ones.

Source files
------------

// File: rtl/hazard_tag_pipe_pkg.sv
// rtl/hazard_tag_pipe_pkg.sv - shared constants and tag decrement helper for the hazard tag pipeline
package hazard_tag_pipe_pkg;

    localparam int TW_DEFAULT = 3;
    localparam int REGW       = 5;
    // Widest tag the decrement helper handles; stage tags are cast into and out of it.
    localparam int TAG_MAXW   = 8;

    localparam logic [REGW-1:0] BUBBLE_REG  = '0;
    localparam logic            BUBBLE_FLAG = 1'b0;

    function automatic logic [TAG_MAXW-1:0] dec(input logic [TAG_MAXW-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// rtl/hazard_tag_stage.sv - one pipeline tag register with bubble load and optional saturating T decrement
module hazard_tag_stage
    import hazard_tag_pipe_pkg::*;
#(
    parameter int TW     = TW_DEFAULT,
    parameter bit DEC_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_bubble,
    input  logic [REGW-1:0] i_rs,
    input  logic [REGW-1:0] i_rt,
    input  logic [REGW-1:0] i_dst,
    input  logic            i_rfwr,
    input  logic            i_dmwr,
    input  logic [TW-1:0]   i_t,
    output logic [REGW-1:0] o_rs,
    output logic [REGW-1:0] o_rt,
    output logic [REGW-1:0] o_dst,
    output logic            o_rfwr,
    output logic            o_dmwr,
    output logic [TW-1:0]   o_t
);

    logic [REGW-1:0] r_rs;
    logic [REGW-1:0] r_rt;
    logic [REGW-1:0] r_dst;
    logic            r_rfwr;
    logic            r_dmwr;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_next;

    generate
        if (DEC_EN) begin : g_dec
            assign w_t_next = TW'(dec(TAG_MAXW'(i_t)));
        end else begin : g_nodec
            assign w_t_next = i_t;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_rs   <= BUBBLE_REG;
            r_rt   <= BUBBLE_REG;
            r_dst  <= BUBBLE_REG;
            r_rfwr <= BUBBLE_FLAG;
            r_dmwr <= BUBBLE_FLAG;
            r_t    <= '0;
        end else begin
            r_rs   <= i_rs;
            r_rt   <= i_rt;
            r_dst  <= i_dst;
            r_rfwr <= i_rfwr;
            r_dmwr <= i_dmwr;
            r_t    <= w_t_next;
        end
    end

    assign o_rs   = r_rs;
    assign o_rt   = r_rt;
    assign o_dst  = r_dst;
    assign o_rfwr = r_rfwr;
    assign o_dmwr = r_dmwr;
    assign o_t    = r_t;

endmodule

// File: rtl/hazard_tag_pipe.sv
// rtl/hazard_tag_pipe.sv - E/M/W destination and latency tag pipeline with flush and bubble counter
module hazard_tag_pipe
    import hazard_tag_pipe_pkg::*;
#(
    parameter int TW   = TW_DEFAULT,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] RsD,
    input  logic [REGW-1:0] RtD,
    input  logic [REGW-1:0] DstD,
    input  logic            RFWrD,
    input  logic            DMWrD,
    input  logic [TW-1:0]   TnewD,
    input  logic            FlushE,
    input  logic            FlushAll,
    output logic [REGW-1:0] RsE,
    output logic [REGW-1:0] RtE,
    output logic [REGW-1:0] DstE,
    output logic [REGW-1:0] DstM,
    output logic [REGW-1:0] DstW,
    output logic            RFWrE,
    output logic            RFWrM,
    output logic            RFWrW,
    output logic [TW-1:0]   TE,
    output logic [TW-1:0]   TM,
    output logic [TW-1:0]   TW_O,
    output logic            DMWrM,
    output logic [CNTW-1:0] BubbleCnt
);

    // Register 0 is never a real write target, so it never raises a hazard.
    logic            w_rfwr_d;
    logic            w_bubble_e;
    logic            w_dmwr_e;
    logic [REGW-1:0] w_unused_rs_m;
    logic [REGW-1:0] w_unused_rt_m;
    logic [REGW-1:0] w_unused_rs_w;
    logic [REGW-1:0] w_unused_rt_w;
    logic            w_unused_dmwr_w;
    logic [CNTW-1:0] r_bubble_cnt;

    assign w_rfwr_d   = RFWrD && (DstD != BUBBLE_REG);
    assign w_bubble_e = FlushE || FlushAll;

    hazard_tag_stage #(.TW(TW), .DEC_EN(1'b0)) u_stage_e (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_bubble_e),
        .i_rs     (RsD),
        .i_rt     (RtD),
        .i_dst    (DstD),
        .i_rfwr   (w_rfwr_d),
        .i_dmwr   (DMWrD),
        .i_t      (TnewD),
        .o_rs     (RsE),
        .o_rt     (RtE),
        .o_dst    (DstE),
        .o_rfwr   (RFWrE),
        .o_dmwr   (w_dmwr_e),
        .o_t      (TE)
    );

    hazard_tag_stage #(.TW(TW), .DEC_EN(1'b1)) u_stage_m (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (FlushAll),
        .i_rs     (BUBBLE_REG),
        .i_rt     (BUBBLE_REG),
        .i_dst    (DstE),
        .i_rfwr   (RFWrE),
        .i_dmwr   (w_dmwr_e),
        .i_t      (TE),
        .o_rs     (w_unused_rs_m),
        .o_rt     (w_unused_rt_m),
        .o_dst    (DstM),
        .o_rfwr   (RFWrM),
        .o_dmwr   (DMWrM),
        .o_t      (TM)
    );

    // W holds a committed instruction, so no flush ever reaches it.
    hazard_tag_stage #(.TW(TW), .DEC_EN(1'b1)) u_stage_w (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_rs     (BUBBLE_REG),
        .i_rt     (BUBBLE_REG),
        .i_dst    (DstM),
        .i_rfwr   (RFWrM),
        .i_dmwr   (BUBBLE_FLAG),
        .i_t      (TM),
        .o_rs     (w_unused_rs_w),
        .o_rt     (w_unused_rt_w),
        .o_dst    (DstW),
        .o_rfwr   (RFWrW),
        .o_dmwr   (w_unused_dmwr_w),
        .o_t      (TW_O)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (FlushE && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign BubbleCnt = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb/tb_hazard_tag_pipe.sv - scoreboard bench for hazard_tag_pipe with directed and random stimulus
module tb_hazard_tag_pipe;

    localparam int TW   = 3;
    localparam int CNTW = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      RsD, RtD, DstD;
    logic            RFWrD, DMWrD;
    logic [TW-1:0]   TnewD;
    logic            FlushE, FlushAll;
    logic [4:0]      RsE, RtE, DstE, DstM, DstW;
    logic            RFWrE, RFWrM, RFWrW;
    logic [TW-1:0]   TE, TM, TW_O;
    logic            DMWrM;
    logic [CNTW-1:0] BubbleCnt;

    always #5 clk = ~clk;

    hazard_tag_pipe #(.TW(TW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .DstD(DstD), .RFWrD(RFWrD), .DMWrD(DMWrD), .TnewD(TnewD),
        .FlushE(FlushE), .FlushAll(FlushAll),
        .RsE(RsE), .RtE(RtE), .DstE(DstE), .DstM(DstM), .DstW(DstW),
        .RFWrE(RFWrE), .RFWrM(RFWrM), .RFWrW(RFWrW),
        .TE(TE), .TM(TM), .TW_O(TW_O), .DMWrM(DMWrM), .BubbleCnt(BubbleCnt)
    );

    typedef struct packed {
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dst;
        logic          rfwr;
        logic          dmwr;
        logic [TW-1:0] t;
    } instr_t;

    instr_t      e_mdl, m_mdl, w_mdl;
    int          cnt_mdl;
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    function automatic logic [TW-1:0] tag_after(input logic [TW-1:0] x, input int stages);
        int v = int'(x) - stages;
        return (v < 0) ? '0 : TW'(v);
    endfunction

    function automatic logic [63:0] snap(
        input instr_t e, input instr_t m, input instr_t w, input logic [CNTW-1:0] c);
        return 64'({e.rs, e.rt, e.dst, e.rfwr, e.t, m.dst, m.rfwr, m.t, m.dmwr,
                    w.dst, w.rfwr, w.t, c});
    endfunction

    function automatic logic [63:0] dut_snap();
        return 64'({RsE, RtE, DstE, RFWrE, TE, DstM, RFWrM, TM, DMWrM,
                    DstW, RFWrW, TW_O, BubbleCnt});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: an instruction seen in D enters E unless flushed; M takes E one stage
    // older unless squashed; W always takes M one stage older.
    task automatic model_step();
        instr_t d, empty;
        empty = '0;
        d = '{rs: RsD, rt: RtD, dst: DstD, rfwr: RFWrD && (DstD != 0), dmwr: DMWrD, t: TnewD};
        if (reset) begin
            e_mdl = empty; m_mdl = empty; w_mdl = empty; cnt_mdl = 0;
        end else begin
            w_mdl = m_mdl;
            w_mdl.dmwr = 1'b0;
            w_mdl.rs = '0; w_mdl.rt = '0;
            w_mdl.t = tag_after(m_mdl.t, 1);
            if (FlushAll) m_mdl = empty;
            else begin
                m_mdl = e_mdl;
                m_mdl.rs = '0; m_mdl.rt = '0;
                m_mdl.t = tag_after(e_mdl.t, 1);
            end
            e_mdl = (FlushE || FlushAll) ? empty : d;
            if (FlushE && cnt_mdl < CNT_MAX) cnt_mdl++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        exp_q.push_back(snap(e_mdl, m_mdl, w_mdl, CNTW'(cnt_mdl)));
        cyc++;
        #1;
    endtask

    task automatic drive_d(input logic [4:0] dst, input logic rfwr, input logic [TW-1:0] tnew);
        RsD = 5'($urandom_range(0, 31));
        RtD = 5'($urandom_range(0, 31));
        DstD = dst; RFWrD = rfwr; DMWrD = 1'($urandom_range(0, 1)); TnewD = tnew;
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("snapshot", dut_snap(), e);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; FlushE = 1'b0; FlushAll = 1'b0;
        drive_d(5'd0, 1'b0, '0);
        cycle(); cycle();
        reset = 1'b0;

        // Reset mid-stream.
        drive_d(5'd7, 1'b1, 3'd3); cycle();
        FlushE = 1'b1; cycle(); FlushE = 1'b0;
        drive_d(5'd9, 1'b1, 3'd1); cycle();
        drive_d(5'd11, 1'b1, 3'd4); cycle();
        reset = 1'b1; FlushE = 1'b1; FlushAll = 1'b1; cycle();
        reset = 1'b0; FlushE = 1'b0; FlushAll = 1'b0;
        chk("reset_dst", 64'({DstE, DstM, DstW}), 64'd0);
        chk("reset_rfwr_t", 64'({RFWrE, RFWrM, RFWrW, TE, TM, TW_O}), 64'd0);
        chk("reset_cnt", 64'(BubbleCnt), 64'd0);

        // Latency decay.
        drive_d(5'd8, 1'b1, 3'd2); cycle();
        drive_d(5'd0, 1'b0, 3'd0);
        chk("decay_e", 64'({DstE, TE}), 64'({5'd8, 3'd2})); cycle();
        chk("decay_m", 64'({DstM, TM}), 64'({5'd8, 3'd1})); cycle();
        chk("decay_w", 64'({DstW, TW_O}), 64'({5'd8, 3'd0}));

        // Tag saturation at zero.
        drive_d(5'd5, 1'b1, 3'd0); cycle();
        drive_d(5'd0, 1'b0, 3'd0);
        chk("sat_e", 64'({RFWrE, TE}), 64'({1'b1, 3'd0})); cycle();
        chk("sat_m", 64'({RFWrM, TM}), 64'({1'b1, 3'd0})); cycle();
        chk("sat_w", 64'({RFWrW, TW_O}), 64'({1'b1, 3'd0}));

        // Register zero never writes.
        drive_d(5'd0, 1'b1, 3'd2); cycle();
        chk("zero_e", 64'(RFWrE), 64'd0); cycle();
        chk("zero_m", 64'(RFWrM), 64'd0); cycle();
        chk("zero_w", 64'(RFWrW), 64'd0);

        // Stall: D held with FlushE for two cycles.
        drive_d(5'd3, 1'b1, 3'd1);
        FlushE = 1'b1; cycle();
        chk("stall_e0", 64'({DstE, RFWrE}), 64'd0); cycle();
        chk("stall_e1", 64'({DstE, RFWrE}), 64'd0);
        FlushE = 1'b0; cycle();
        chk("stall_release", 64'(DstE), 64'd3);
        drive_d(5'd0, 1'b0, 3'd0); cycle();
        chk("stall_once", 64'({DstE, DstM}), 64'({5'd0, 5'd3}));
        chk("stall_cnt", 64'(BubbleCnt), 64'd2);

        // FlushAll with E=4, M=6.
        drive_d(5'd6, 1'b1, 3'd2); cycle();
        drive_d(5'd4, 1'b1, 3'd2); cycle();
        drive_d(5'd9, 1'b1, 3'd2);
        FlushAll = 1'b1; cycle(); FlushAll = 1'b0;
        chk("flushall_em", 64'({DstE, RFWrE, DstM, RFWrM}), 64'd0);
        chk("flushall_w", 64'({DstW, RFWrW}), 64'({5'd6, 1'b1}));
        chk("flushall_cnt", 64'(BubbleCnt), 64'd2);

        // Counter saturation.
        FlushE = 1'b1;
        for (int i = 0; i < CNT_MAX + 4; i++) cycle();
        FlushE = 1'b0;
        chk("cnt_sat", 64'(BubbleCnt), 64'(CNT_MAX));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive_d(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), TW'($urandom_range(0, 7)));
            FlushE   = ($urandom_range(0, 3) == 0);
            FlushAll = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 1'b0; FlushE = 1'b0; FlushAll = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
